tag_stream_generator: RTL and testbench

// Synthetic time-tag source: the transmit end of the multi-lane tag interface (valid_tag/tagtime/channel) consumed by countrate and the other tag sinks.

---
 rtl/tag_stream_if.sv | 13 +
 rtl/tag_stream_generator.sv | 236 +++++++++++++++++++++++
 tb/tb_tag_stream_generator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tag_stream_if.sv
// Multi-lane time-tag bus: per-lane valid plus packed timestamps and channel ids.
interface tag_stream_if #(
    parameter int unsigned TAG_WIDTH     = 64,
    parameter int unsigned NUM_OF_TAGS   = 4,
    parameter int unsigned CHANNEL_WIDTH = 6
);
    logic [NUM_OF_TAGS-1:0]               valid_tag;
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     tagtime;
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] channel;

    modport master (output valid_tag, tagtime, channel);
    modport slave  (input  valid_tag, tagtime, channel);
endinterface

// File: rtl/tag_stream_generator.sv
// Synthetic time-tag source: deterministic bursts of monotonic tags with round-robin channels.
// Define TAG_GEN_JITTER_EN to add LFSR jitter (0..15) to every tag increment.
module tag_stream_generator #(
    parameter int unsigned TAG_WIDTH       = 64,
    parameter int unsigned NUM_OF_TAGS     = 4,
    parameter int unsigned CHANNEL_WIDTH   = 6,
    parameter int unsigned NUM_OF_CHANNELS = 4,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             stop,
    input  logic [TAG_WIDTH-1:0]             start_time,
    input  logic [31:0]                      tag_step,
    input  logic [$clog2(NUM_OF_TAGS+1)-1:0] lanes_per_cycle,
    input  logic [CHANNEL_WIDTH-1:0]         num_channels,
    input  logic [15:0]                      on_cycles,
    input  logic [15:0]                      off_cycles,
    input  logic [COUNT_WIDTH-1:0]           num_tags,
    tag_stream_if.master                     tag_if,
    output logic                             busy,
    output logic                             done,
    output logic [COUNT_WIDTH-1:0]           tags_emitted
);
    localparam int unsigned LANE_W = $clog2(NUM_OF_TAGS + 1);
    localparam int unsigned SUM_W  = COUNT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t                             state_q, state_d;
    logic [LANE_W-1:0]                  lanes_q, lanes_d;
    logic [CHANNEL_WIDTH-1:0]           nch_q, nch_d;
    logic [31:0]                        step_q, step_d;
    logic [15:0]                        on_q, on_d, off_q, off_d;
    logic                               unlimited_q, unlimited_d;
    logic [COUNT_WIDTH-1:0]             remaining_q, remaining_d;
    logic [TAG_WIDTH-1:0]               next_time_q, next_time_d;
    logic [CHANNEL_WIDTH-1:0]           next_ch_q, next_ch_d;
    logic [15:0]                        on_cnt_q, on_cnt_d, gap_cnt_q, gap_cnt_d;
    logic [NUM_OF_TAGS-1:0]             valid_q, valid_d;
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]   tagtime_q, tagtime_d;
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] channel_q, channel_d;
    logic                               busy_q, busy_d, done_q, done_d;
    logic [COUNT_WIDTH-1:0]             emitted_q, emitted_d;
`ifdef TAG_GEN_JITTER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    logic [15:0]                        lfsr_q, lfsr_d, lfsr_acc;
`endif

    logic [1:0]               rst_sync_q;
    logic                     rst_ready;
    logic [LANE_W-1:0]        lanes_clamp, emit_n;
    logic [CHANNEL_WIDTH-1:0] nch_clamp, c_acc;
    logic [TAG_WIDTH-1:0]     t_acc;
    logic [SUM_W-1:0]         sum;
    logic                     finished, last_burst;

    // Reset deassertion is synchronised here; start is ignored until it has propagated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ready = rst_sync_q[1];

    assign lanes_clamp = (lanes_per_cycle == '0 || lanes_per_cycle > LANE_W'(NUM_OF_TAGS))
                         ? LANE_W'(NUM_OF_TAGS) : lanes_per_cycle;
    assign nch_clamp   = (num_channels == '0) ? CHANNEL_WIDTH'(1)
                       : (num_channels > CHANNEL_WIDTH'(NUM_OF_CHANNELS)) ? CHANNEL_WIDTH'(NUM_OF_CHANNELS)
                       : num_channels;

    assign finished   = !unlimited_q && (remaining_q == '0);
    assign emit_n     = (!unlimited_q && (remaining_q < COUNT_WIDTH'(lanes_q)))
                        ? LANE_W'(remaining_q) : lanes_q;
    assign last_burst = !unlimited_q && (remaining_q == COUNT_WIDTH'(emit_n));

    // Next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        nch_d       = nch_q;
        step_d      = step_q;
        on_d        = on_q;
        off_d       = off_q;
        unlimited_d = unlimited_q;
        remaining_d = remaining_q;
        next_time_d = next_time_q;
        next_ch_d   = next_ch_q;
        on_cnt_d    = on_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        busy_d      = busy_q;
        emitted_d   = emitted_q;
        valid_d     = '0;
        tagtime_d   = '0;
        channel_d   = '0;
        done_d      = 1'b0;
        t_acc       = next_time_q;
        c_acc       = next_ch_q;
        sum         = '0;
`ifdef TAG_GEN_JITTER_EN
        lfsr_d      = lfsr_q;
        lfsr_acc    = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop && rst_ready) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    lanes_d     = lanes_clamp;
                    nch_d       = nch_clamp;
                    step_d      = tag_step;
                    on_d        = on_cycles;
                    off_d       = off_cycles;
                    unlimited_d = (num_tags == '0);
                    remaining_d = num_tags;
                    next_time_d = start_time;
                    next_ch_d   = '0;
                    on_cnt_d    = '0;
                    gap_cnt_d   = '0;
                    emitted_d   = '0;
`ifdef TAG_GEN_JITTER_EN
                    lfsr_d      = LFSR_SEED;
`endif
                end
            end
            RUN: begin
                if (stop || finished) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_OF_TAGS; k++) begin
                        if (LANE_W'(k) < emit_n) begin
                            valid_d[k] = 1'b1;
                            tagtime_d[k*TAG_WIDTH +: TAG_WIDTH]         = t_acc;
                            channel_d[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] = c_acc;
`ifdef TAG_GEN_JITTER_EN
                            t_acc    = t_acc + TAG_WIDTH'(step_q) + TAG_WIDTH'(lfsr_acc[3:0]);
                            lfsr_acc = {1'b0, lfsr_acc[15:1]} ^ (lfsr_acc[0] ? LFSR_TAPS : 16'h0000);
`else
                            t_acc    = t_acc + TAG_WIDTH'(step_q);
`endif
                            c_acc = (c_acc == nch_q - CHANNEL_WIDTH'(1)) ? '0 : c_acc + CHANNEL_WIDTH'(1);
                        end
                    end
                    next_time_d = t_acc;
                    next_ch_d   = c_acc;
`ifdef TAG_GEN_JITTER_EN
                    lfsr_d      = lfsr_acc;
`endif
                    if (!unlimited_q) remaining_d = remaining_q - COUNT_WIDTH'(emit_n);
                    sum       = SUM_W'(emitted_q) + SUM_W'(emit_n);
                    emitted_d = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
                    // The final burst stays in RUN so done lands right after the last valid cycle
                    if (on_q != '0 && off_q != '0 && !last_burst) begin
                        if (on_cnt_q == on_q - 16'd1) begin
                            state_d   = GAP;
                            on_cnt_d  = '0;
                            gap_cnt_d = '0;
                        end else begin
                            on_cnt_d = on_cnt_q + 16'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (stop || finished) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == off_q - 16'd1) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lanes_q     <= '0;
            nch_q       <= '0;
            step_q      <= '0;
            on_q        <= '0;
            off_q       <= '0;
            unlimited_q <= 1'b0;
            remaining_q <= '0;
            next_time_q <= '0;
            next_ch_q   <= '0;
            on_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= '0;
            tagtime_q   <= '0;
            channel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            emitted_q   <= '0;
`ifdef TAG_GEN_JITTER_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            nch_q       <= nch_d;
            step_q      <= step_d;
            on_q        <= on_d;
            off_q       <= off_d;
            unlimited_q <= unlimited_d;
            remaining_q <= remaining_d;
            next_time_q <= next_time_d;
            next_ch_q   <= next_ch_d;
            on_cnt_q    <= on_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= valid_d;
            tagtime_q   <= tagtime_d;
            channel_q   <= channel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            emitted_q   <= emitted_d;
`ifdef TAG_GEN_JITTER_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign tag_if.valid_tag = valid_q;
    assign tag_if.tagtime   = tagtime_q;
    assign tag_if.channel   = channel_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign tags_emitted     = emitted_q;
endmodule

// File: tb/tb_tag_stream_generator.sv
// Scoreboard bench for tag_stream_generator: a model queues per-cycle lane/busy/done records and tags.
module tb_tag_stream_generator;
    localparam int unsigned TW = 64, NT = 4, CW = 6, NC = 4, CNTW = 32;

    logic            clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0;
    logic [TW-1:0]   start_time = '0;
    logic [31:0]     tag_step = '0;
    logic [2:0]      lanes_per_cycle = '0;
    logic [CW-1:0]   num_channels = '0;
    logic [15:0]     on_cycles = '0, off_cycles = '0;
    logic [CNTW-1:0] num_tags = '0;
    logic            busy, done;
    logic [CNTW-1:0] tags_emitted;

    tag_stream_if #(.TAG_WIDTH(TW), .NUM_OF_TAGS(NT), .CHANNEL_WIDTH(CW)) tag_if ();

    tag_stream_generator #(.TAG_WIDTH(TW), .NUM_OF_TAGS(NT), .CHANNEL_WIDTH(CW),
                           .NUM_OF_CHANNELS(NC), .COUNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .start_time(start_time), .tag_step(tag_step), .lanes_per_cycle(lanes_per_cycle),
        .num_channels(num_channels), .on_cycles(on_cycles), .off_cycles(off_cycles),
        .num_tags(num_tags), .tag_if(tag_if), .busy(busy), .done(done),
        .tags_emitted(tags_emitted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT-1:0] valid;
        logic          busy;
        logic          done;
    } cyc_t;

    cyc_t          cyc_q[$];
    logic [TW-1:0] time_q[$];
    logic [CW-1:0] ch_q[$];
    cyc_t          mon_e;
    int            vectors = 0, miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cyc(input logic [NT-1:0] v, input logic b, input logic d);
        cyc_t e;
        e.valid = v; e.busy = b; e.done = d;
        cyc_q.push_back(e);
    endtask

    // Reference model for a finite run: tag n = t0 + n*step, channel n mod nch
    task automatic expect_run(input logic [TW-1:0] t0, input logic [31:0] step, input int lanes,
                              input int nch, input int on, input int off, input int n);
        int rem, burst, l;
        for (int i = 0; i < n; i++) begin
            time_q.push_back(t0 + TW'(i) * TW'(step));
            ch_q.push_back(CW'(i % nch));
        end
        push_cyc('0, 1'b1, 1'b0);
        rem = n;
        burst = 0;
        while (rem > 0) begin
            l = (rem < lanes) ? rem : lanes;
            push_cyc(NT'((1 << l) - 1), 1'b1, 1'b0);
            rem -= l;
            burst++;
            if (rem > 0 && on != 0 && off != 0 && burst == on) begin
                burst = 0;
                repeat (off) push_cyc('0, 1'b1, 1'b0);
            end
        end
        push_cyc('0, 1'b0, 1'b1);
        push_cyc('0, 1'b0, 1'b0);
    endtask

    // Pulse start with a config, then scramble the inputs to show they are ignored while busy
    task automatic launch(input logic [TW-1:0] t0, input logic [31:0] step, input logic [2:0] l,
                          input logic [CW-1:0] nch, input logic [15:0] on, input logic [15:0] off,
                          input logic [CNTW-1:0] n);
        @(negedge clk);
        start_time = t0; tag_step = step; lanes_per_cycle = l; num_channels = nch;
        on_cycles = on; off_cycles = off; num_tags = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_time = 64'($urandom); tag_step = $urandom; lanes_per_cycle = 3'($urandom);
        num_channels = 6'($urandom); on_cycles = 16'($urandom); off_cycles = 16'($urandom);
        num_tags = $urandom;
    endtask

    task automatic drain(input logic [CNTW-1:0] exp_count);
        int budget;
        budget = 500;
        while (cyc_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check_val("drain_in_time", 64'(budget > 0), 64'd1);
        check_val("tags_emitted", 64'(tags_emitted), 64'(exp_count));
        check_val("tags_left", 64'(time_q.size()), 64'd0);
    endtask

    // Monitor: one expected record per cycle, one expected tag per valid lane
    always @(negedge clk) begin
        if (cyc_q.size() != 0) begin
            mon_e = cyc_q.pop_front();
            check_val("valid_tag", 64'(tag_if.valid_tag), 64'(mon_e.valid));
            check_val("busy", 64'(busy), 64'(mon_e.busy));
            check_val("done", 64'(done), 64'(mon_e.done));
            for (int k = 0; k < NT; k++) begin
                if (tag_if.valid_tag[k]) begin
                    check_val("tag_expected", 64'(time_q.size() != 0), 64'd1);
                    if (time_q.size() != 0) begin
                        check_val("tagtime", tag_if.tagtime[k*TW +: TW], time_q.pop_front());
                        check_val("channel", 64'(tag_if.channel[k*CW +: CW]), 64'(ch_q.pop_front()));
                    end
                end else begin
                    check_val("idle_tagtime", tag_if.tagtime[k*TW +: TW], 64'd0);
                    check_val("idle_channel", 64'(tag_if.channel[k*CW +: CW]), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid", 64'(tag_if.valid_tag), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_emitted", 64'(tags_emitted), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Two full cycles of four lanes
        launch(64'd1000, 32'd10, 3'd4, 6'd4, 16'd0, 16'd0, 32'd8);
        expect_run(64'd1000, 32'd10, 4, 4, 0, 0, 8);
        drain(32'd8);

        // Partial final cycle, two channels
        launch(64'd500, 32'd3, 3'd3, 6'd2, 16'd0, 16'd0, 32'd7);
        expect_run(64'd500, 32'd3, 3, 2, 0, 0, 7);
        drain(32'd7);

        // Bursts of 2 active, 3 idle
        launch(64'd0, 32'd5, 3'd4, 6'd4, 16'd2, 16'd3, 32'd16);
        expect_run(64'd0, 32'd5, 4, 4, 2, 3, 16);
        drain(32'd16);

        // Unlimited run stopped after 5 active cycles
        launch(64'd100, 32'd1, 3'd4, 6'd4, 16'd0, 16'd0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            time_q.push_back(64'd100 + 64'(i));
            ch_q.push_back(CW'(i % 4));
        end
        push_cyc('0, 1'b1, 1'b0);
        repeat (5) push_cyc(4'b1111, 1'b1, 1'b0);
        push_cyc('0, 1'b0, 1'b1);
        push_cyc('0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        drain(32'd20);

        // Asynchronous reset mid-run, then an identical replay
        launch(64'd1000, 32'd10, 3'd4, 6'd4, 16'd0, 16'd0, 32'd40);
        expect_run(64'd1000, 32'd10, 4, 4, 0, 0, 40);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_valid", 64'(tag_if.valid_tag), 64'd0);
        check_val("abort_time0", tag_if.tagtime[0 +: TW], 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_emitted", 64'(tags_emitted), 64'd0);
        cyc_q.delete();
        time_q.delete();
        ch_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        launch(64'd1000, 32'd10, 3'd4, 6'd4, 16'd0, 16'd0, 32'd8);
        expect_run(64'd1000, 32'd10, 4, 4, 0, 0, 8);
        drain(32'd8);

        // Timestamp wrap at 2^64
        launch(64'hFFFF_FFFF_FFFF_FFEC, 32'd10, 3'd4, 6'd4, 16'd0, 16'd0, 32'd4);
        expect_run(64'hFFFF_FFFF_FFFF_FFEC, 32'd10, 4, 4, 0, 0, 4);
        drain(32'd4);

        // Clamping: lanes 0 -> 4, channels 9 -> 4; off=0 keeps the run continuous
        launch(64'd77, 32'd1, 3'd0, 6'd9, 16'd1, 16'd0, 32'd10);
        expect_run(64'd77, 32'd1, 4, 4, 0, 0, 10);
        drain(32'd10);

        // start and stop together while idle: nothing starts
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("ss_busy", 64'(busy), 64'd0);
            check_val("ss_valid", 64'(tag_if.valid_tag), 64'd0);
            check_val("ss_done", 64'(done), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
